// File: rtl/board_rider.sv
// Player-side board contact resolver: decides landing, riding, head bump and
// leaving against one moving board, and emits the corrected player Y each frame.
module board_rider #(
   parameter int unsigned BOARD_W       = 64,
   parameter int unsigned BOARD_H       = 14,
   parameter int unsigned PLAYER_W      = 20,
   parameter int unsigned PLAYER_H      = 35,
   parameter int unsigned BOARD_Y_RESET = 248
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [9:0] BoardX,
   input  logic [9:0] BoardY,
   input  logic [9:0] PlayerX,
   input  logic [9:0] PlayerY,
   input  logic [9:0] PlayerYNext,
   output logic [9:0] PlayerYOut,
   output logic       OnBoard,
   output logic       HeadBump,
   output logic [9:0] CarryDY
);

   typedef enum logic [0:0] {
      FREE   = 1'b0,
      RIDING = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [9:0] board_y_prev_q;
   logic [9:0] player_y_q, player_y_d;
   logic [9:0] carry_dy_q, carry_dy_d;
   logic       on_board_q, on_board_d;
   logic       head_bump_q, head_bump_d;

   logic [10:0] bx_s, by_s, px_s, py_s, pyn_s, prev_s;
   logic        ovl_s, land_s, bump_s;
   logic [9:0]  land_tgt_s, dy_s, bump_y_s;

   // Zero-extend to 11 bits so position + size sums never wrap in comparisons.
   assign bx_s   = {1'b0, BoardX};
   assign by_s   = {1'b0, BoardY};
   assign px_s   = {1'b0, PlayerX};
   assign py_s   = {1'b0, PlayerY};
   assign pyn_s  = {1'b0, PlayerYNext};
   assign prev_s = {1'b0, board_y_prev_q};

   assign ovl_s      = (px_s + 11'(PLAYER_W) > bx_s) && (px_s < bx_s + 11'(BOARD_W));
   assign land_tgt_s = (by_s < 11'(PLAYER_H)) ? 10'd0 : (BoardY - 10'(PLAYER_H));
   assign dy_s       = BoardY - board_y_prev_q;
   assign bump_y_s   = BoardY + 10'(BOARD_H);

   // Land: feet were above the board's previous top and the proposed move reaches it.
   assign land_s = ovl_s && (py_s + 11'(PLAYER_H) <= prev_s)
                         && (pyn_s + 11'(PLAYER_H) >= by_s);
   assign bump_s = ovl_s && (py_s >= prev_s + 11'(BOARD_H))
                         && (pyn_s < by_s + 11'(BOARD_H));

   // Contact resolution and next-state selection.
   always_comb begin
      state_d     = state_q;
      player_y_d  = PlayerYNext;
      on_board_d  = 1'b0;
      head_bump_d = 1'b0;
      carry_dy_d  = 10'd0;
      case (state_q)
         FREE: begin
            if (land_s) begin
               player_y_d = land_tgt_s;
               on_board_d = 1'b1;
               state_d    = RIDING;
            end else if (bump_s) begin
               player_y_d  = bump_y_s;
               head_bump_d = 1'b1;
            end else begin
               player_y_d = PlayerYNext;
            end
         end
         RIDING: begin
            if (!ovl_s || (PlayerYNext < PlayerY)) begin
               player_y_d = PlayerYNext;
               state_d    = FREE;
            end else begin
               player_y_d = land_tgt_s;
               on_board_d = 1'b1;
               carry_dy_d = dy_s;
            end
         end
         default: begin
            state_d = FREE;
         end
      endcase
   end

   // State, previous board Y and registered outputs.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= FREE;
         board_y_prev_q <= 10'(BOARD_Y_RESET);
         player_y_q     <= 10'd0;
         on_board_q     <= 1'b0;
         head_bump_q    <= 1'b0;
         carry_dy_q     <= 10'd0;
      end else begin
         state_q        <= state_d;
         board_y_prev_q <= BoardY;
         player_y_q     <= player_y_d;
         on_board_q     <= on_board_d;
         head_bump_q    <= head_bump_d;
         carry_dy_q     <= carry_dy_d;
      end
   end

   assign PlayerYOut = player_y_q;
   assign OnBoard    = on_board_q;
   assign HeadBump   = head_bump_q;
   assign CarryDY    = carry_dy_q;

endmodule

// File: tb/tb_board_rider.sv
// Randomised and directed check of board_rider against a frame-level reference
// model of the contact rules.
module tb_board_rider;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [9:0] BoardX, BoardY, PlayerX, PlayerY, PlayerYNext;
   logic [9:0] PlayerYOut, CarryDY;
   logic       OnBoard, HeadBump;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit m_riding;
   int m_prev;
   int m_out;

   board_rider dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .BoardX      (BoardX),
      .BoardY      (BoardY),
      .PlayerX     (PlayerX),
      .PlayerY     (PlayerY),
      .PlayerYNext (PlayerYNext),
      .PlayerYOut  (PlayerYOut),
      .OnBoard     (OnBoard),
      .HeadBump    (HeadBump),
      .CarryDY     (CarryDY)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_riding = 1'b0;
      m_prev   = 248;
      m_out    = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_yout"}, {22'd0, PlayerYOut}, 32'd0);
      check_eq({tag, "_on"},   {31'd0, OnBoard},    32'd0);
      check_eq({tag, "_hb"},   {31'd0, HeadBump},   32'd0);
      check_eq({tag, "_cdy"},  {22'd0, CarryDY},    32'd0);
   endtask

   // One frame: drive inputs, predict, clock, compare, advance the model.
   task automatic step(input string tag, input int bx, input int by, input int px,
                       input int py, input int pyn);
      int  e_out, e_on, e_hb, e_cdy, tgt;
      bit  ovl, nxt_riding;
      BoardX = 10'(bx); BoardY = 10'(by); PlayerX = 10'(px);
      PlayerY = 10'(py); PlayerYNext = 10'(pyn);
      ovl = (px + 20 > bx) && (px < bx + 64);
      tgt = (by < 35) ? 0 : by - 35;
      e_out = pyn; e_on = 0; e_hb = 0; e_cdy = 0; nxt_riding = m_riding;
      if (!m_riding) begin
         if (ovl && py + 35 <= m_prev && pyn + 35 >= by) begin
            e_out = tgt; e_on = 1; nxt_riding = 1'b1;
         end else if (ovl && py >= m_prev + 14 && pyn < by + 14) begin
            e_out = (by + 14) % 1024; e_hb = 1;
         end
      end else begin
         if (!ovl || pyn < py) begin
            nxt_riding = 1'b0;
         end else begin
            e_out = tgt; e_on = 1; e_cdy = (by - m_prev + 1024) % 1024;
         end
      end
      @(posedge frame_clk);
      #1;
      check_eq({tag, "_yout"}, {22'd0, PlayerYOut}, 32'(e_out));
      check_eq({tag, "_on"},   {31'd0, OnBoard},    32'(e_on));
      check_eq({tag, "_hb"},   {31'd0, HeadBump},   32'(e_hb));
      check_eq({tag, "_cdy"},  {22'd0, CarryDY},    32'(e_cdy));
      m_riding = nxt_riding;
      m_prev   = by;
      m_out    = e_out;
   endtask

   // Assert reset between clock edges and expect immediate clearing.
   task automatic async_reset(input string tag);
      #2;
      Reset = 1'b1;
      #1;
      check_reset_outputs(tag);
      #1;
      Reset = 1'b0;
      model_reset();
   endtask

   function automatic int clamp10(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   initial begin
      int bx, by, px, py, pyn, last_by;
      Reset = 1'b1;
      BoardX = 10'd77; BoardY = 10'd500; PlayerX = 10'd3;
      PlayerY = 10'd900; PlayerYNext = 10'd1;
      model_reset();
      repeat (3) @(posedge frame_clk);
      #1;
      check_reset_outputs("reset");
      Reset = 1'b0;

      // Landing, then riding descent
      step("land",   14, 248, 30, 200, 215);
      step("ride1",  14, 249, 30, 213, 213);
      step("ride2",  14, 250, 30, 214, 214);
      // Walk off exactly at the right edge (78 == 14+64)
      step("walkoff", 14, 250, 78, 215, 220);
      // Settle board at 248, then head bump and its one-frame pulse
      step("settle", 14, 248, 200, 300, 300);
      step("bump",   14, 248, 30, 263, 258);
      step("bumpend", 14, 248, 200, 262, 262);
      // Left-edge non-overlap (0+20 == 20)
      step("ledge",  20, 248, 0, 200, 215);
      // Land, then jump off
      step("reland", 14, 248, 30, 200, 215);
      step("jump",   14, 248, 30, 213, 205);
      // Clamped land target with a board near the top
      step("clamp",  0, 20, 10, 100, 100);
      step("clampride", 0, 20, 10, 0, 0);
      // Re-land and reset mid-ride
      step("land3",  14, 248, 30, 205, 215);
      async_reset("midreset");
      step("postrst_land", 14, 248, 30, 200, 215);
      step("postrst_ride", 14, 248, 30, 213, 213);

      last_by = 248;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            async_reset("rnd_rst");
            last_by = 248;
         end
         bx = $urandom_range(0, 300);
         if ($urandom_range(0, 5) == 0) by = $urandom_range(0, 1023);
         else by = clamp10(last_by + $urandom_range(0, 6) - 3);
         px = clamp10(bx + $urandom_range(0, 100) - 30);
         case ($urandom_range(0, 3))
            0: py = m_out;
            1: py = clamp10(by - 35 - $urandom_range(0, 10));
            2: py = clamp10(by + 14 + $urandom_range(0, 10));
            default: py = $urandom_range(0, 1023);
         endcase
         pyn = clamp10(py + $urandom_range(0, 30) - 15);
         if ($urandom_range(0, 3) == 0) pyn = py;
         step("rnd", bx, by, px, py, pyn);
         last_by = by;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
